// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multi-cycle MIPS datapath.
// It steps each instruction through FETCH / DECODE / EXEC / MEM / WB. It drives
// the datapath mux selects and the PC/IR/register/memory enables, and it waits
// on mem_ready in the FETCH and MEM states.
// The control outputs are decoded combinationally from the current state and
// from op/funct. While rst_n is low, every output (state included) is held at 0.
// Optional build macro: JAL_EN adds support for jal (op 000011).
// Without it, jal decodes as illegal.
//
// state | meaning
// ------+---------------------------------------------------------
// 0     | FETCH  : read instruction memory, load IR and PC+4 when ready
// 1     | DECODE : classify op/funct, resolve j (and jal if enabled)
// 2     | EXEC   : ALU operation, beq resolves here
// 3     | MEM    : lw/sw data access, held until mem_ready
// 4     | WB     : register-file write, instruction retires
// 5-7   | unused : return to FETCH with all enables low

module multicycle_ctrl #(
    parameter int STATE_W = 3,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_wr,
    output logic               ir_wr,
    output logic [1:0]         npc_sel,
    output logic [1:0]         reg_dst,
    output logic               alu_src,
    output logic [1:0]         data_to_reg,
    output logic               ext_op,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_wr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               retire,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 'd0,
        S_DECODE = 'd1,
        S_EXEC   = 'd2,
        S_MEM    = 'd3,
        S_WB     = 'd4
    } state_e;

    typedef enum logic [3:0] {
        C_ADDU,
        C_SUBU,
        C_ORI,
        C_LUI,
        C_LW,
        C_SW,
        C_BEQ,
        C_J,
        C_JAL,
        C_ILL
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
`ifdef JAL_EN
    localparam logic [1:0] DST_RA   = 2'b10;
    localparam logic [1:0] WB_PC4   = 2'b10;
`endif

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(3);

    state_e  state_q;
    state_e  state_d;
    iclass_e cls;

    // Classify the instruction currently held in IR.
    always_comb begin
        cls = C_ILL;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU) begin
                    cls = C_ADDU;
                end else if (funct == FN_SUBU) begin
                    cls = C_SUBU;
                end else begin
                    cls = C_ILL;
                end
            end
            OP_ORI:  cls = C_ORI;
            OP_LUI:  cls = C_LUI;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  cls = C_BEQ;
            OP_J:    cls = C_J;
`ifdef JAL_EN
            OP_JAL:  cls = C_JAL;
`endif
            default: cls = C_ILL;
        endcase
    end

    // Next-state selection from the current state, the class and mem_ready.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (cls)
                    C_ILL, C_J: state_d = S_FETCH;
                    C_JAL:      state_d = S_WB;
                    default:    state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_LW, C_SW:                   state_d = S_MEM;
                    C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_WB;
                    default:                      state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (!mem_ready) begin
                    state_d = S_MEM;
                end else if (cls == C_LW) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Control outputs, all forced low while reset is asserted.
    always_comb begin
        pc_wr       = 1'b0;
        ir_wr       = 1'b0;
        npc_sel     = NPC_SEQ;
        reg_dst     = DST_RT;
        alu_src     = 1'b0;
        data_to_reg = WB_ALU;
        ext_op      = 1'b0;
        alu_op      = ALU_ADD;
        reg_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        pc_wr   = 1'b1;
                        ir_wr   = 1'b1;
                        npc_sel = NPC_SEQ;
                    end
                end
                S_DECODE: begin
                    case (cls)
                        C_ILL: illegal = 1'b1;
                        C_J: begin
                            pc_wr   = 1'b1;
                            npc_sel = NPC_JMP;
                            retire  = 1'b1;
                        end
                        C_JAL: begin
                            pc_wr   = 1'b1;
                            npc_sel = NPC_JMP;
                        end
                        default: ;
                    endcase
                end
                S_EXEC: begin
                    case (cls)
                        C_ADDU: alu_op = ALU_ADD;
                        C_SUBU: alu_op = ALU_SUB;
                        C_ORI: begin
                            alu_src = 1'b1;
                            alu_op  = ALU_OR;
                        end
                        C_LUI: begin
                            alu_src = 1'b1;
                            alu_op  = ALU_LUI;
                        end
                        C_LW, C_SW: begin
                            alu_src = 1'b1;
                            ext_op  = 1'b1;
                            alu_op  = ALU_ADD;
                        end
                        C_BEQ: begin
                            alu_op  = ALU_SUB;
                            ext_op  = 1'b1;
                            npc_sel = NPC_BR;
                            pc_wr   = zero;
                            retire  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (cls == C_LW) begin
                        mem_rd = 1'b1;
                    end else if (cls == C_SW) begin
                        mem_wr = 1'b1;
                        retire = mem_ready;
                    end
                end
                S_WB: begin
                    case (cls)
                        C_ADDU, C_SUBU: begin
                            reg_wr      = 1'b1;
                            retire      = 1'b1;
                            reg_dst     = DST_RD;
                            data_to_reg = WB_ALU;
                        end
                        C_ORI, C_LUI: begin
                            reg_wr      = 1'b1;
                            retire      = 1'b1;
                            reg_dst     = DST_RT;
                            data_to_reg = WB_ALU;
                        end
                        C_LW: begin
                            reg_wr      = 1'b1;
                            retire      = 1'b1;
                            reg_dst     = DST_RT;
                            data_to_reg = WB_MEM;
                        end
`ifdef JAL_EN
                        C_JAL: begin
                            reg_wr      = 1'b1;
                            retire      = 1'b1;
                            reg_dst     = DST_RA;
                            data_to_reg = WB_PC4;
                        end
`endif
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = rst_n ? state_q : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction streams for multicycle_ctrl, with
// random fetch/data stalls. For each instruction the bench builds the expected
// per-cycle state and control vector from the instruction's phase list, then
// checks the DUT against it cycle by cycle. Define JAL_EN to exercise jal.

module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_wr;
        logic       ir_wr;
        logic [1:0] npc_sel;
        logic [1:0] reg_dst;
        logic       alu_src;
        logic [1:0] data_to_reg;
        logic       ext_op;
        logic [2:0] alu_op;
        logic       reg_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       retire;
        logic       illegal;
    } outs_t;

    typedef struct packed {
        logic [2:0] st;
        outs_t      o;
        logic       mr;
        logic       z;
        logic       rl;
    } cyc_t;

`ifdef JAL_EN
    localparam bit JAL_ON = 1'b1;
`else
    localparam bit JAL_ON = 1'b0;
`endif

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                   K_SW = 5, K_BEQ = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       pc_wr, ir_wr, alu_src, ext_op, reg_wr, mem_rd, mem_wr, retire, illegal;
    logic [1:0] npc_sel, reg_dst, data_to_reg;
    logic [2:0] alu_op, state;
    outs_t      obs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.STATE_W(3), .ALUOP_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr), .npc_sel(npc_sel),
        .reg_dst(reg_dst), .alu_src(alu_src), .data_to_reg(data_to_reg),
        .ext_op(ext_op), .alu_op(alu_op), .reg_wr(reg_wr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .retire(retire), .illegal(illegal), .state(state)
    );

    assign obs = '{pc_wr, ir_wr, npc_sel, reg_dst, alu_src, data_to_reg, ext_op,
                   alu_op, reg_wr, mem_rd, mem_wr, retire, illegal};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_supported(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b000000) return (f == 6'b100001) || (f == 6'b100011);
        return (o == 6'b001101) || (o == 6'b001111) || (o == 6'b100011) ||
               (o == 6'b101011) || (o == 6'b000100) || (o == 6'b000010) ||
               (o == 6'b000011);
    endfunction

    function automatic cyc_t mk(input int st, input outs_t o, input bit mr, input bit z, input bit rl);
        cyc_t c;
        c.st = 3'(st);
        c.o  = o;
        c.mr = mr;
        c.z  = z;
        c.rl = rl;
        return c;
    endfunction

    // Drive one instruction and compare every cycle against its expected phase list.
    task automatic run_inst(input int kind, input int fs, input int ms, input int zf, input string nm);
        logic [5:0] iop, ifn;
        cyc_t       q[$];
        outs_t      o;
        bit         zb, ill;
        ifn = 6'($urandom);
        case (kind)
            K_ADDU: begin iop = 6'b000000; ifn = 6'b100001; end
            K_SUBU: begin iop = 6'b000000; ifn = 6'b100011; end
            K_ORI:  iop = 6'b001101;
            K_LUI:  iop = 6'b001111;
            K_LW:   iop = 6'b100011;
            K_SW:   iop = 6'b101011;
            K_BEQ:  iop = 6'b000100;
            K_J:    iop = 6'b000010;
            K_JAL:  iop = 6'b000011;
            default: begin
                iop = 6'b111111;
                if (zf == 1) begin
                    iop = 6'b000000;
                    do ifn = 6'($urandom); while (is_supported(iop, ifn));
                end else if (zf == 2) begin
                    do iop = 6'($urandom); while (is_supported(iop, ifn));
                end
            end
        endcase
        ill = (kind == K_ILL) || (kind == K_JAL && !JAL_ON);

        for (int i = 0; i < fs; i++) begin
            o = '0; o.mem_rd = 1'b1;
            q.push_back(mk(0, o, 1'b0, 1'($urandom), 1'b0));
        end
        o = '0; o.mem_rd = 1'b1; o.pc_wr = 1'b1; o.ir_wr = 1'b1;
        q.push_back(mk(0, o, 1'b1, 1'($urandom), 1'b0));

        o = '0;
        if (ill) o.illegal = 1'b1;
        else if (kind == K_J) begin o.pc_wr = 1'b1; o.npc_sel = 2'b10; o.retire = 1'b1; end
        else if (kind == K_JAL) begin o.pc_wr = 1'b1; o.npc_sel = 2'b10; end
        q.push_back(mk(1, o, 1'($urandom), 1'($urandom), 1'b1));

        if (!ill && kind != K_J && kind != K_JAL) begin
            zb = (zf < 0) ? 1'($urandom) : 1'(zf);
            o = '0;
            case (kind)
                K_SUBU: o.alu_op = 3'd1;
                K_ORI:  begin o.alu_src = 1'b1; o.alu_op = 3'd2; end
                K_LUI:  begin o.alu_src = 1'b1; o.alu_op = 3'd3; end
                K_LW, K_SW: begin o.alu_src = 1'b1; o.ext_op = 1'b1; end
                K_BEQ: begin
                    o.alu_op = 3'd1; o.ext_op = 1'b1; o.npc_sel = 2'b01;
                    o.pc_wr = zb; o.retire = 1'b1;
                end
                default: ;
            endcase
            q.push_back(mk(2, o, 1'($urandom), zb, 1'b1));
        end

        if (kind == K_LW || kind == K_SW) begin
            for (int i = 0; i <= ms; i++) begin
                o = '0;
                if (kind == K_LW) o.mem_rd = 1'b1;
                else o.mem_wr = 1'b1;
                if (i == ms && kind == K_SW) o.retire = 1'b1;
                q.push_back(mk(3, o, (i == ms), 1'($urandom), 1'b1));
            end
        end

        if (!ill && kind != K_J && kind != K_BEQ && kind != K_SW) begin
            o = '0; o.reg_wr = 1'b1; o.retire = 1'b1;
            if (kind == K_ADDU || kind == K_SUBU) o.reg_dst = 2'b01;
            if (kind == K_LW) o.data_to_reg = 2'b01;
            if (kind == K_JAL) begin o.reg_dst = 2'b10; o.data_to_reg = 2'b10; end
            q.push_back(mk(4, o, 1'($urandom), 1'($urandom), 1'b1));
        end

        foreach (q[k]) begin
            op        = q[k].rl ? iop : 6'($urandom);
            funct     = q[k].rl ? ifn : 6'($urandom);
            mem_ready = q[k].mr;
            zero      = q[k].z;
            @(negedge clk);
            check_eq($sformatf("%s c%0d state", nm, k), 32'(state), 32'(q[k].st));
            check_eq($sformatf("%s c%0d outs", nm, k), 32'(obs), 32'(q[k].o));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        outs_t o;
        int    kind;
        rst_n = 1'b0; op = 6'b000000; funct = 6'b100001; zero = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("init_rst state", 32'(state), 32'd0);
            check_eq("init_rst outs", 32'(obs), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_inst(K_ADDU, 0, 0, -1, "addu");
        run_inst(K_LW, 0, 3, -1, "lw_stall");
        run_inst(K_BEQ, 1, 0, 1, "beq_taken");
        run_inst(K_BEQ, 0, 0, 0, "beq_not");
        run_inst(K_ILL, 0, 0, 0, "op3f");
        run_inst(K_JAL, 0, 0, -1, "jal");
        run_inst(K_SW, 2, 1, -1, "sw");
        run_inst(K_J, 0, 0, -1, "j");

        // Reset asserted for two cycles while an addu sits in EXEC.
        op = 6'b000000; funct = 6'b100001; mem_ready = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        check_eq("mid_exec state", 32'(state), 32'd2);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_mid state", 32'(state), 32'd0);
            check_eq("rst_mid outs", 32'(obs), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        o = '0; o.mem_rd = 1'b1;
        check_eq("post_rst state", 32'(state), 32'd0);
        check_eq("post_rst outs", 32'(obs), 32'(o));
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            run_inst(kind, $urandom_range(0, 3), $urandom_range(0, 3),
                     (kind == K_ILL) ? $urandom_range(0, 2) : -1,
                     $sformatf("rnd%0d_k%0d", n, kind));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
